// File: rtl/tx_pid.sv
// tx_pid: 8N1 UART transmitter that sends the latched KP/KI/KD gains as ASCII "PP,II,DD".
// Optional macro TX_PID_NEWLINE_EN appends a '\n' terminator character to every frame.
module tx_pid #(
    parameter int CPB = 434
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] kp,
    input  logic [5:0] ki,
    input  logic [5:0] kd,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CW = (CPB > 1) ? $clog2(CPB) : 1;
`ifdef TX_PID_NEWLINE_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [5:0]    kp_q, kp_d;
    logic [5:0]    ki_q, ki_d;
    logic [5:0]    kd_q, kd_d;
    logic [7:0]    cur_char;
    logic [2:0]    next_bit;
    logic          bit_end;
    logic          accept;

    function automatic logic [7:0] tens_char(input logic [5:0] v);
        logic [5:0] t;
        t = v / 6'd10;
        return 8'h30 + {2'b00, t};
    endfunction

    function automatic logic [7:0] ones_char(input logic [5:0] v);
        logic [5:0] o;
        o = v % 6'd10;
        return 8'h30 + {2'b00, o};
    endfunction

    always_comb begin
        case (idx_q)
            4'd0:    cur_char = tens_char(kp_q);
            4'd1:    cur_char = ones_char(kp_q);
            4'd3:    cur_char = tens_char(ki_q);
            4'd4:    cur_char = ones_char(ki_q);
            4'd6:    cur_char = tens_char(kd_q);
            4'd7:    cur_char = ones_char(kd_q);
`ifdef TX_PID_NEWLINE_EN
            4'd8:    cur_char = 8'h0A;
`endif
            default: cur_char = 8'h2C;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        idx_d    = idx_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        kp_d     = kp_q;
        ki_d     = ki_q;
        kd_d     = kd_q;
        accept   = 1'b0;
        bit_end  = (cnt_q == CW'(CPB - 1));
        next_bit = bit_q + 3'd1;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: accept = start;
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = cur_char[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_char[next_bit];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_IDX) begin
                        // Frame ends here; a waiting start chains the next frame with no idle gap.
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        idx_d   = 4'd0;
                        accept  = start;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_q + 4'd1;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_START;
            busy_d  = 1'b1;
            tx_d    = 1'b0;
            idx_d   = 4'd0;
            cnt_d   = '0;
            kp_d    = kp;
            ki_d    = ki;
            kd_d    = kd;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk_50m) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            idx_q   <= 4'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the gain latches are pure data reloaded on every accept, so they carry no reset.
    always_ff @(posedge clk_50m) begin
        kp_q <= kp_d;
        ki_q <= ki_d;
        kd_q <= kd_d;
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_tx_pid.sv
// tb_tx_pid: directed bench for tx_pid; decodes every bit cycle of each frame against hand-computed bytes.
// Honours TX_PID_NEWLINE_EN so the expected frame length follows the build.
module tb_tx_pid;
    localparam int CPB = 10;
`ifdef TX_PID_NEWLINE_EN
    localparam int NCH = 9;
`else
    localparam int NCH = 8;
`endif
    localparam int FRAME = NCH * 10 * CPB;

    logic       clk_50m = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] kp;
    logic [5:0] ki;
    logic [5:0] kd;
    logic       tx;
    logic       busy;
    logic       done;

    logic [7:0] exp_q [9];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #10 clk_50m = ~clk_50m;

    tx_pid #(.CPB(CPB)) dut (
        .clk_50m (clk_50m),
        .reset   (reset),
        .start   (start),
        .kp      (kp),
        .ki      (ki),
        .kd      (kd),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Present gains with start for one edge; returns at the first negedge after the accept edge.
    task automatic launch(input logic [5:0] p, input logic [5:0] i, input logic [5:0] d, input bit hold);
        @(negedge clk_50m);
        kp    = p;
        ki    = i;
        kd    = d;
        start = 1'b1;
        @(negedge clk_50m);
        if (!hold) start = 1'b0;
    endtask

    // Samples every cycle of a frame: each bit level must hold for exactly CPB cycles.
    task automatic watch_frame(input string tag, input int disturb_at);
        int         width_err;
        int         busy_err;
        int         done_err;
        int         cyc;
        logic       exp_bit;
        logic [7:0] got;
        width_err = 0;
        busy_err  = 0;
        done_err  = 0;
        for (int c = 0; c < NCH; c++) begin
            got = 8'h00;
            for (int b = 0; b < 10; b++) begin
                if (b == 0)      exp_bit = 1'b0;
                else if (b == 9) exp_bit = 1'b1;
                else             exp_bit = exp_q[c][b-1];
                for (int k = 0; k < CPB; k++) begin
                    cyc = c * 10 * CPB + b * CPB + k;
                    if (disturb_at >= 0 && cyc == disturb_at) begin
                        kp    = 6'd1;
                        ki    = 6'd1;
                        kd    = 6'd1;
                        start = 1'b1;
                    end else if (disturb_at >= 0 && cyc == disturb_at + 1) begin
                        start = 1'b0;
                    end
                    if (tx !== exp_bit) width_err++;
                    if (busy !== 1'b1) busy_err++;
                    if (cyc > 0 && done !== 1'b0) done_err++;
                    if (k == CPB / 2 && b >= 1 && b <= 8) got[b-1] = tx;
                    @(negedge clk_50m);
                end
            end
            check($sformatf("%s char%0d", tag, c), got, exp_q[c]);
        end
        check($sformatf("%s bit levels/widths", tag), width_err, 0);
        check($sformatf("%s busy held", tag), busy_err, 0);
        check($sformatf("%s no early done", tag), done_err, 0);
    endtask

    task automatic check_end(input string tag, input bit chained);
        check($sformatf("%s done", tag), done, 1'b1);
        check($sformatf("%s busy", tag), busy, chained);
        check($sformatf("%s tx", tag), tx, !chained);
        if (!chained) begin
            @(negedge clk_50m);
            check($sformatf("%s done width", tag), done, 1'b0);
        end
    endtask

    initial begin
        int quiet_err;
        reset = 1'b1;
        start = 1'b0;
        kp    = 6'd0;
        ki    = 6'd0;
        kd    = 6'd0;
        repeat (3) @(negedge clk_50m);
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        reset = 1'b0;
        @(negedge clk_50m);
        check("idle tx", tx, 1'b1);
        check("idle busy", busy, 1'b0);

        // 3,1,5 -> "03,01,05"
        exp_q = '{8'h30, 8'h33, 8'h2C, 8'h30, 8'h31, 8'h2C, 8'h30, 8'h35, 8'h0A};
        launch(6'd3, 6'd1, 6'd5, 1'b0);
        watch_frame("t1", -1);
        check_end("t1", 1'b0);

        // 63,0,10 -> "63,00,10"
        exp_q = '{8'h36, 8'h33, 8'h2C, 8'h30, 8'h30, 8'h2C, 8'h31, 8'h30, 8'h0A};
        launch(6'd63, 6'd0, 6'd10, 1'b0);
        watch_frame("t2", -1);
        check_end("t2", 1'b0);

        // start held: 7,42,0 -> "07,42,00" twice, second start bit on the done edge
        exp_q = '{8'h30, 8'h37, 8'h2C, 8'h34, 8'h32, 8'h2C, 8'h30, 8'h30, 8'h0A};
        launch(6'd7, 6'd42, 6'd0, 1'b1);
        watch_frame("t3a", -1);
        check_end("t3a", 1'b1);
        start = 1'b0;
        watch_frame("t3b", -1);
        check_end("t3b", 1'b0);

        // 20,9,63 -> "20,09,63"; gains change and start pulses mid-frame
        exp_q = '{8'h32, 8'h30, 8'h2C, 8'h30, 8'h39, 8'h2C, 8'h36, 8'h33, 8'h0A};
        launch(6'd20, 6'd9, 6'd63, 1'b0);
        watch_frame("t4", FRAME / 2);
        check_end("t4", 1'b0);
        repeat (3) @(negedge clk_50m);
        check("t4 no queued frame", busy, 1'b0);

        // 11,22,33: reset in char 4 ('2' = 8'h32), data bit 3 (= 0)
        launch(6'd11, 6'd22, 6'd33, 1'b0);
        repeat (4 * 10 * CPB + 4 * CPB + 2) @(negedge clk_50m);
        check("t5 pre-reset tx", tx, 1'b0);
        check("t5 pre-reset busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk_50m);
        check("t5 reset tx", tx, 1'b1);
        check("t5 reset busy", busy, 1'b0);
        check("t5 reset done", done, 1'b0);
        reset = 1'b0;
        quiet_err = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk_50m);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) quiet_err++;
        end
        check("t5 quiet after reset", quiet_err, 0);

        // 45,6,38 -> "45,06,38" restarts from char 0
        exp_q = '{8'h34, 8'h35, 8'h2C, 8'h30, 8'h36, 8'h2C, 8'h33, 8'h38, 8'h0A};
        launch(6'd45, 6'd6, 6'd38, 1'b0);
        watch_frame("t5b", -1);
        check_end("t5b", 1'b0);

        // 12,34,56 -> "12,34,56" (plus '\n' when the terminator is built)
        exp_q = '{8'h31, 8'h32, 8'h2C, 8'h33, 8'h34, 8'h2C, 8'h35, 8'h36, 8'h0A};
        launch(6'd12, 6'd34, 6'd56, 1'b0);
        watch_frame("t6", -1);
        check_end("t6", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
